// File: rtl/comm_frame_sender.sv
// One-wire pulse-width-coded frame transmitter for the inter-board pong link.
// Define COMM_PARITY_EN to append an even-parity bit after the payload LSB.
module comm_frame_sender #(
    parameter int HDR_W     = 3,
    parameter int PAYLOAD_W = 17,
    parameter int BIT_CYC   = 63,
    parameter int T0H_CYC   = 20,
    parameter int T1H_CYC   = 40,
    parameter int GAP_CYC   = 2500
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 msg_valid,
    output logic                 msg_ready,
    input  logic [HDR_W-1:0]     msg_hdr,
    input  logic [PAYLOAD_W-1:0] msg_payload,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 drop,
    output logic                 line_out
);

`ifdef COMM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FRAME_W = HDR_W + PAYLOAD_W + PAR_W;
    localparam int CNT_W   = $clog2(BIT_CYC);
    localparam int IDX_W   = $clog2(FRAME_W + 1);
    localparam int GAP_W   = $clog2(GAP_CYC + 1);

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] T0H       = CNT_W'(T0H_CYC);
    localparam logic [CNT_W-1:0] T1H       = CNT_W'(T1H_CYC);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0] LAST_GAP  = GAP_W'(GAP_CYC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BIT  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   slot_cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic [GAP_W-1:0]   gap_cnt;
    logic [FRAME_W-1:0] shift_reg;
    logic               accept;
    logic               slot_end;

    function automatic logic [FRAME_W-1:0] build_frame(input logic [HDR_W-1:0]     hdr,
                                                       input logic [PAYLOAD_W-1:0] payload);
`ifdef COMM_PARITY_EN
        return {hdr, payload, ^{hdr, payload}};
`else
        return {hdr, payload};
`endif
    endfunction

    assign msg_ready  = (state == ST_IDLE);
    assign busy       = ~msg_ready;
    assign accept     = msg_valid && msg_ready;
    assign slot_end   = (state == ST_BIT) && (slot_cnt == LAST_SLOT);
    assign frame_done = (state == ST_GAP) && (gap_cnt == LAST_GAP);
    // Decoded from registered state so an async reset pulls the line low at once.
    assign line_out   = (state == ST_BIT) &&
                        (slot_cnt < (shift_reg[FRAME_W-1] ? T1H : T0H));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            slot_cnt <= '0;
            bit_idx  <= '0;
            gap_cnt  <= '0;
            drop     <= 1'b0;
        end else begin
            drop <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (msg_hdr != '0) begin
                            state    <= ST_BIT;
                            slot_cnt <= '0;
                            bit_idx  <= '0;
                        end else begin
                            drop <= 1'b1;
                        end
                    end
                end
                ST_BIT: begin
                    if (slot_end) begin
                        slot_cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
                            state   <= ST_GAP;
                            gap_cnt <= '0;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        slot_cnt <= slot_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Data path carries no reset; the FSM alone decides when shift_reg is meaningful.
    always_ff @(posedge clock) begin
        if (accept) begin
            shift_reg <= build_frame(msg_hdr, msg_payload);
        end else if (slot_end) begin
            shift_reg <= shift_reg << 1;
        end
    end

endmodule

// File: tb/tb_comm_frame_sender.sv
// Bench for comm_frame_sender: per-cycle comparison against a waveform-queue reference model.
module tb_comm_frame_sender;
    localparam int HDR_W     = 3;
    localparam int PAYLOAD_W = 4;
    localparam int BIT_CYC   = 6;
    localparam int T0H_CYC   = 2;
    localparam int T1H_CYC   = 4;
    localparam int GAP_CYC   = 3;
`ifdef COMM_PARITY_EN
    localparam int FRAME_W = HDR_W + PAYLOAD_W + 1;
`else
    localparam int FRAME_W = HDR_W + PAYLOAD_W;
`endif

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 msg_valid = 1'b0;
    logic [HDR_W-1:0]     msg_hdr = '0;
    logic [PAYLOAD_W-1:0] msg_payload = '0;
    logic                 msg_ready, busy, frame_done, drop, line_out;

    comm_frame_sender #(
        .HDR_W(HDR_W), .PAYLOAD_W(PAYLOAD_W), .BIT_CYC(BIT_CYC),
        .T0H_CYC(T0H_CYC), .T1H_CYC(T1H_CYC), .GAP_CYC(GAP_CYC)
    ) dut (
        .clock(clock), .reset(reset), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_hdr(msg_hdr), .msg_payload(msg_payload), .busy(busy),
        .frame_done(frame_done), .drop(drop), .line_out(line_out)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = -1;
    bit exp_q[$];      // expected line level for each upcoming cycle of the frame in flight
    bit drop_pending = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Expected line waveform: one slot per frame bit, MSB first, then the low gap.
    task automatic push_frame(input logic [HDR_W-1:0] h, input logic [PAYLOAD_W-1:0] p);
        logic [FRAME_W-1:0] f;
`ifdef COMM_PARITY_EN
        f = {h, p, ^{h, p}};
`else
        f = {h, p};
`endif
        for (int i = FRAME_W - 1; i >= 0; i--)
            for (int c = 0; c < BIT_CYC; c++)
                exp_q.push_back(c < (f[i] ? T1H_CYC : T0H_CYC));
        for (int g = 0; g < GAP_CYC; g++)
            exp_q.push_back(1'b0);
    endtask

    task automatic step(input logic v, input logic [HDR_W-1:0] h, input logic [PAYLOAD_W-1:0] p);
        bit e_line, e_done, e_ready;
        @(negedge clock);
        cyc++;
        e_ready = (exp_q.size() == 0);
        e_line  = e_ready ? 1'b0 : exp_q[0];
        e_done  = (exp_q.size() == 1);
        check_eq("line_out",   32'(line_out),   32'(e_line));
        check_eq("frame_done", 32'(frame_done), 32'(e_done));
        check_eq("msg_ready",  32'(msg_ready),  32'(e_ready));
        check_eq("busy",       32'(busy),       32'(!e_ready));
        check_eq("drop",       32'(drop),       32'(drop_pending));
        if (frame_done === 1'b1)
            check_eq("frame_cost", 32'(cyc - acc_cyc), 32'(FRAME_W * BIT_CYC + GAP_CYC));
        if (!e_ready) void'(exp_q.pop_front());
        drop_pending = 1'b0;
        msg_valid   = v;
        msg_hdr     = h;
        msg_payload = p;
        if (v && e_ready && !reset) begin
            if (h != '0) begin
                push_frame(h, p);
                acc_cyc = cyc;
            end else begin
                drop_pending = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, HDR_W'($urandom), PAYLOAD_W'($urandom));
    endtask

    initial begin
        // Reset state
        step(1'b0, '0, '0);
        step(1'b0, '0, '0);
        reset = 1'b0;
        idle(2);

        // Basic frame, then reserved header, then all-ones frame
        step(1'b1, 3'b100, 4'b1010);
        idle(FRAME_W * BIT_CYC + GAP_CYC + 3);
        step(1'b1, 3'b000, 4'hF);
        idle(3);
        step(1'b1, 3'b111, 4'b1111);
        idle(FRAME_W * BIT_CYC + GAP_CYC + 3);

        // Valid held high with data churning while busy
        step(1'b1, 3'b101, 4'b0011);
        for (int i = 0; i < 2 * (FRAME_W * BIT_CYC + GAP_CYC) + 5; i++)
            step(1'b1, HDR_W'($urandom_range(1, 7)), PAYLOAD_W'($urandom));
        idle(FRAME_W * BIT_CYC + GAP_CYC + 3);

        // Async reset while slot 3 is driving high
        step(1'b1, 3'b100, 4'b1010);
        idle(3 * BIT_CYC + 1);
        check_eq("pre_reset_line", 32'(line_out), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_eq("reset_line",  32'(line_out),  32'd0);
        check_eq("reset_ready", 32'(msg_ready), 32'd1);
        check_eq("reset_busy",  32'(busy),      32'd0);
        exp_q.delete();
        drop_pending = 1'b0;
        msg_valid = 1'b0;
        step(1'b0, '0, '0);
        step(1'b0, '0, '0);
        reset = 1'b0;
        idle(FRAME_W * BIT_CYC + GAP_CYC + 3);

        // Randomized traffic, including reserved headers
        for (int k = 0; k < 1500; k++)
            step(($urandom_range(0, 3) == 0), HDR_W'($urandom), PAYLOAD_W'($urandom));
        idle(FRAME_W * BIT_CYC + GAP_CYC + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
